// File: rtl/apu_frame_counter_if.sv
// apu_frame_counter_if: cycle-pulse, $4017 write, $4015 ack and frame strobe/IRQ signals
interface apu_frame_counter_if;
  logic apu_cycle_pulse_in;
  logic mode_wr_in;
  logic mode_in;
  logic irq_inhibit_in;
  logic irq_ack_in;
  logic quarter_frame_out;
  logic half_frame_out;
  logic frame_irq_out;
  modport master (
    output apu_cycle_pulse_in, mode_wr_in, mode_in, irq_inhibit_in, irq_ack_in,
    input  quarter_frame_out, half_frame_out, frame_irq_out
  );
  modport slave (
    input  apu_cycle_pulse_in, mode_wr_in, mode_in, irq_inhibit_in, irq_ack_in,
    output quarter_frame_out, half_frame_out, frame_irq_out
  );
endinterface

// File: rtl/apu_frame_counter.sv
// apu_frame_counter: APU frame sequencer with quarter/half-frame strobes and frame IRQ; define APU_FRAME_PAL_EN for PAL step timing
module apu_frame_counter #(
  parameter int CNT_BITS = 15
) (
  input logic clk_in,
  input logic rst_n_in,
  apu_frame_counter_if.slave bus
);
`ifdef APU_FRAME_PAL_EN
  localparam logic [CNT_BITS-1:0] S1 = CNT_BITS'(4156);
  localparam logic [CNT_BITS-1:0] S2 = CNT_BITS'(8313);
  localparam logic [CNT_BITS-1:0] S3 = CNT_BITS'(12469);
  localparam logic [CNT_BITS-1:0] S4 = CNT_BITS'(16626);
  localparam logic [CNT_BITS-1:0] S5 = CNT_BITS'(20782);
`else
  localparam logic [CNT_BITS-1:0] S1 = CNT_BITS'(3728);
  localparam logic [CNT_BITS-1:0] S2 = CNT_BITS'(7456);
  localparam logic [CNT_BITS-1:0] S3 = CNT_BITS'(11185);
  localparam logic [CNT_BITS-1:0] S4 = CNT_BITS'(14914);
  localparam logic [CNT_BITS-1:0] S5 = CNT_BITS'(18640);
`endif
  logic [CNT_BITS-1:0] q_cnt;
  logic q_mode, q_inhibit, q_irq, q_qf, q_hf;
  logic at_term, step_qf, step_hf, irq_set;
  assign bus.quarter_frame_out = q_qf;
  assign bus.half_frame_out = q_hf;
  assign bus.frame_irq_out = q_irq;
  // Decode the step the counter sits on; mode 1 passes S4 silently and ends at S5
  always_comb begin
    at_term = q_cnt == (q_mode ? S5 : S4);
    step_qf = q_cnt == S1 || q_cnt == S2 || q_cnt == S3 || at_term;
    step_hf = q_cnt == S2 || at_term;
    irq_set = bus.apu_cycle_pulse_in && !bus.mode_wr_in && !q_mode && q_cnt == S4 && !q_inhibit;
  end
  // Advance on APU cycles; a $4017 write restarts the sequence and wins over the step decode
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      q_cnt <= '0;
      q_mode <= 1'b0;
      q_inhibit <= 1'b0;
      q_irq <= 1'b0;
      q_qf <= 1'b0;
      q_hf <= 1'b0;
    end else begin
      q_irq <= irq_set || (q_irq && !bus.irq_ack_in && !(bus.mode_wr_in && bus.irq_inhibit_in));
      if (bus.mode_wr_in) begin
        q_mode <= bus.mode_in;
        q_inhibit <= bus.irq_inhibit_in;
        q_cnt <= '0;
        q_qf <= bus.mode_in;
        q_hf <= bus.mode_in;
      end else begin
        q_qf <= bus.apu_cycle_pulse_in && step_qf;
        q_hf <= bus.apu_cycle_pulse_in && step_hf;
        if (bus.apu_cycle_pulse_in) q_cnt <= at_term ? '0 : q_cnt + CNT_BITS'(1);
      end
    end
endmodule

// File: doc/apu_frame_counter.md
Name: apu_frame_counter

Overview:
- APU frame sequencer: counts APU cycles and emits the quarter-frame and half-frame strobes that clock the envelope, linear-counter, length-counter and sweep units.
- Also owns the frame IRQ flag.
- Sits beside the channel dividers, driven by the same cpu/apu cycle pulses.
- Configured by CPU writes to register $4017; the IRQ flag is cleared by the $4015 read strobe.

Parameters:
- CNT_BITS, 15, width of the APU-cycle step counter; must hold the largest step value (18640 NTSC, 20782 PAL).

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset; asynchronous, active-low.
- apu_cycle_pulse_in  input  1  one-clk strobe per APU cycle (every 2nd CPU cycle); the counter advances only on this strobe.
- mode_wr_in  input  1  one-clk strobe for a $4017 write.
- mode_in  input  1  written mode: 0 = 4-step, 1 = 5-step.
- irq_inhibit_in  input  1  written IRQ-inhibit bit.
- irq_ack_in  input  1  one-clk strobe for a $4015 read; clears the frame IRQ flag.
- quarter_frame_out  output  1  one-clk strobe: clock envelopes and triangle linear counter.
- half_frame_out  output  1  one-clk strobe: clock length counters and sweeps.
- frame_irq_out  output  1  frame IRQ flag level.

Behaviour:
- State registers:
  - q_cnt [CNT_BITS-1:0]
  - q_mode
  - q_inhibit
  - q_irq
  - registered strobes q_qf and q_hf
- Reset, asynchronous on rst_n_in low: all state registers 0 (mode 0, inhibit 0, IRQ clear, no strobes). Release takes effect at the next clk_in edge.
- Step values, NTSC default:
  - S1 = 3728, S2 = 7456, S3 = 11185
  - S4 = 14914 (mode 0)
  - S5 = 18640 (mode 1)
- Counter:
  - Changes only on clocks where apu_cycle_pulse_in = 1.
  - next = 0 if q_cnt equals the terminal step (S4 in mode 0, S5 in mode 1); otherwise next = q_cnt + 1.
  - Period: 14915 APU cycles in mode 0, 18641 in mode 1.
- Step decode, evaluated on an apu_cycle_pulse_in clock using the current q_cnt:
  - S1, S3: quarter only.
  - S2: quarter + half.
  - Mode 0 at S4: quarter + half; also sets q_irq if q_inhibit = 0.
  - Mode 1 at S4: nothing (no IRQ).
  - Mode 1 at S5: quarter + half.
- Strobe latency: strobes are registered and appear on the clock after the decoding edge, high for exactly one clk.
- Write (mode_wr_in = 1):
  - q_mode <= mode_in; q_inhibit <= irq_inhibit_in; q_cnt <= 0.
  - The write overrides any coincident step decode and apu_cycle_pulse_in advance.
  - If mode_in = 1: quarter and half strobes fire (registered, next clk).
  - If irq_inhibit_in = 1: q_irq cleared.
- IRQ flag:
  - Set by the mode-0 S4 event.
  - Cleared by irq_ack_in or by a write with inhibit = 1.
  - If set and clear coincide, set wins, so the flag is never lost.
  - frame_irq_out = q_irq (registered, no combinational path from inputs).
- Mode change mid-frame: takes effect immediately. The counter restarts from 0, so no partial-period artifacts.
- No strobe without apu_cycle_pulse_in, except the mode-1 write strobe.

Optional Feature:
- Macro APU_FRAME_PAL_EN.
- Defined: PAL step values S1 = 4156, S2 = 8313, S3 = 12469, S4 = 16626, S5 = 20782.
- Undefined: NTSC values above.
- All other behaviour is identical.

Test Plan:
- Reset, then 14915 apu pulses in mode 0:
  - quarter strobes after pulses at q_cnt = 3728, 7456, 11185, 14914.
  - half strobes at 7456 and 14914 only.
  - frame_irq_out rises the clk after the 14914 decode.
  - q_cnt returns to 0.
- Write mode 1, inhibit 0:
  - quarter and half strobes on the next clk.
  - q_cnt = 0.
  - No IRQ over 18641 pulses.
  - Strobes at 3728, 7456, 11185, 18640; none at 14914.
- IRQ set in mode 0, then irq_ack_in:
  - frame_irq_out falls the next clk.
  - irq_ack_in on the same clk as the S4 decode leaves frame_irq_out = 1.
- Write inhibit = 1 while IRQ set:
  - flag clears the next clk.
  - A full mode-0 period with inhibit = 1 never sets it.
- Write on the same clk as apu_cycle_pulse_in at q_cnt = 3728 in mode 0:
  - no quarter strobe.
  - q_cnt = 0.
- Assert rst_n_in low mid-frame (q_cnt = 9000, IRQ set, no clk edge):
  - all outputs 0 immediately.
  - After release, first quarter strobe follows the pulse at q_cnt = 3728.
